dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
Data-memory responder for the riscv core's data port. It is the target end of the data_ce/data_we/data_addr/data bus that the core drives from its MEM stage. It serves a word-addressed RAM, a memory-mapped console TX FIFO drained over a valid/ready stream, and a 64-bit cycle counter with a coherent high-word snapshot. It sits beside the core in the top-level testbench/SoC, and its read path returns data in the same cycle, so MEM_WB captures it at the next edge.

Parameters:
ADDR_BITWIDTH, 10, log2 of RAM depth in words (RAM = 2^ADDR_BITWIDTH x 32).
WORD_BITWIDTH, 32, data/address width.
FIFO_DEPTH_BITS, 3, log2 of console FIFO depth (default 8 entries).
MMIO_BASE, 32'h1000_0000, base address of the MMIO window.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
data_ce_i  input  1  read request (core memRead).
data_we_i  input  1  write request (core memWrite).
data_addr_i  input  WORD_BITWIDTH  byte address; bits [1:0] ignored.
data_i  input  WORD_BITWIDTH  store data from core.
data_o  output  WORD_BITWIDTH  load data to core; combinational.
tx_valid_o  output  1  console FIFO non-empty.
tx_data_o  output  8  FIFO head byte.
tx_ready_i  input  1  sink accepts head when tx_valid_o is high.
bad_access_o  output  1  sticky flag: an access hit an unmapped address.

Behaviour:
- Reset (async, rst=1): FIFO pointers and count = 0, tx_valid_o=0, tx_data_o=0, overflow=0, cycle counter=0, hi_snap=0, bad_access_o=0. RAM contents are not reset. data_o follows its combinational rule.
- Reset mid-operation flushes the FIFO; bytes not yet popped are lost.
- Address decode:
  - RAM: data_addr_i[31:28]==4'h0, word index data_addr_i[ADDR_BITWIDTH+1:2]; higher offset bits alias.
  - MMIO registers, offsets from MMIO_BASE:
    - +0x0 CONSOLE_TX (W): push data_i[7:0].
    - +0x4 STATUS (R: {29'b0, overflow, full, empty}; W: any value clears overflow).
    - +0x8 CYCLE_LO (R).
    - +0xC CYCLE_HI (R, returns hi_snap).
  - Anything else is unmapped: reads return 0, writes are ignored, bad_access_o is set on the next edge and stays set until rst.
- Reads: data_o = selected value when data_ce_i=1, else 0. Latency is 0 cycles, combinational from data_addr_i.
- Writes: take effect at the rising edge where data_we_i=1.
- data_ce_i and data_we_i both high: data_o returns the pre-write value, and the write commits at the edge.
- Cycle counter: 64-bit, increments every cycle after reset and wraps from 2^64-1 to 0.
  - A read of CYCLE_LO (data_ce_i=1) returns counter[31:0] and loads hi_snap <= counter[63:32] at that edge.
  - Software reads LO then HI for a coherent value.
- Console FIFO:
  - Circular buffer of 2^FIFO_DEPTH_BITS bytes, read pointer, write pointer and count of FIFO_DEPTH_BITS+1 bits. Pointers wrap modulo depth.
  - tx_valid_o = (count!=0); tx_data_o = head byte.
  - Pop on an edge where tx_valid_o && tx_ready_i.
  - Push on a CONSOLE_TX write:
    - Not full: accepted.
    - Full with a simultaneous pop: accepted, count unchanged.
    - Full without a pop: dropped, overflow is set and stays set until a STATUS write or rst.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Push to an empty FIFO: tx_valid_o rises the next cycle, so there is no same-cycle bypass.
  - tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- No stall output: every core access completes in the cycle it is presented.

Test Plan:
- Write 32'hDEADBEEF to RAM address 0x40 → next cycle, data_ce_i=1 at address 0x40 returns 32'hDEADBEEF; address 0x42 returns the same value because bits [1:0] are ignored. Read and write to 0x40 in the same cycle → data_o shows the old value, and the new value appears next cycle.
- Push bytes 0x41,0x42,0x43 with tx_ready_i=0 → tx_valid_o=1 and tx_data_o=0x41 held. Raise tx_ready_i for 3 cycles → outputs 0x41,0x42,0x43 in order, then tx_valid_o=0 and STATUS=3'b001.
- Push 9 bytes into an 8-deep FIFO with tx_ready_i=0 → STATUS=3'b110 and the 9th byte is dropped. Write STATUS → overflow clears. With the FIFO full, push and pop in the same cycle → push accepted, count stays 8, and the pop order shows wrap-around.
- Run 100 cycles after reset, then read CYCLE_LO → returns ~100. Force counter[31:0]=32'hFFFF_FFFF, read LO then HI two cycles apart → HI equals the pre-carry snapshot, not the incremented upper word.
- Read 0x2000_0000 → data_o=0 and bad_access_o=1 from the next cycle, still 1 after 10 idle cycles.
- Assert rst while the FIFO holds 4 bytes and tx_ready_i=0 → tx_valid_o drops immediately (async) and the counter reads 0 after release. RAM data written before reset is still readable.

Source files
------------

// File: rtl/dmem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_mmio                                                       |
// | Brief    : Data-port responder with RAM, console TX FIFO and cycle counter. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_mmio #(
  parameter int ADDR_BITWIDTH   = 10,
  parameter int WORD_BITWIDTH   = 32,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter logic [WORD_BITWIDTH-1:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [WORD_BITWIDTH-1:0] data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] data_i,
  output logic [WORD_BITWIDTH-1:0] data_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     bad_access_o
);

  localparam int c_depth     = 2 ** FIFO_DEPTH_BITS;
  localparam int c_ram_words = 2 ** ADDR_BITWIDTH;

  localparam logic [1:0] c_reg_tx     = 2'd0;
  localparam logic [1:0] c_reg_status = 2'd1;
  localparam logic [1:0] c_reg_lo     = 2'd2;
  localparam logic [1:0] c_reg_hi     = 2'd3;

  localparam logic [FIFO_DEPTH_BITS:0]   c_full_count = c_depth[FIFO_DEPTH_BITS:0];
  localparam logic [FIFO_DEPTH_BITS:0]   c_cnt_one    = {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_BITS-1:0] c_ptr_one    = {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [2*WORD_BITWIDTH-1:0] c_cycle_one  = {{(2*WORD_BITWIDTH-1){1'b0}}, 1'b1};

  logic [WORD_BITWIDTH-1:0]   r_ram  [0:c_ram_words-1];
  logic [7:0]                 r_fifo [0:c_depth-1];
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic                       r_overflow;
  logic [2*WORD_BITWIDTH-1:0] r_cycle;
  logic [WORD_BITWIDTH-1:0]   r_hi_snap;
  logic                       r_bad;

  logic                     w_sel_ram;
  logic                     w_sel_mmio;
  logic                     w_unmapped;
  logic [1:0]               w_reg;
  logic [ADDR_BITWIDTH-1:0] w_ram_idx;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_push_ok;
  logic                     w_status_wr;
  logic                     w_lo_rd;
  logic                     w_unused_ok;

  // RAM aliases across every offset bit above the word index.
  assign w_sel_ram   = (data_addr_i[WORD_BITWIDTH-1 -: 4] == 4'h0);
  assign w_sel_mmio  = (data_addr_i[WORD_BITWIDTH-1:4] == MMIO_BASE[WORD_BITWIDTH-1:4]);
  assign w_unmapped  = !w_sel_ram && !w_sel_mmio;
  assign w_reg       = data_addr_i[3:2];
  assign w_ram_idx   = data_addr_i[ADDR_BITWIDTH+1:2];
  assign w_unused_ok = &{1'b0, data_addr_i[1:0]};

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_full_count);
  assign w_pop       = !w_empty && tx_ready_i;
  assign w_push      = data_we_i && w_sel_mmio && (w_reg == c_reg_tx);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_status_wr = data_we_i && w_sel_mmio && (w_reg == c_reg_status);
  assign w_lo_rd     = data_ce_i && w_sel_mmio && (w_reg == c_reg_lo);

  assign tx_valid_o   = !w_empty;
  assign tx_data_o    = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign bad_access_o = r_bad;

  always_comb begin
    data_o = '0;
    if (data_ce_i) begin
      if (w_sel_ram) begin
        data_o = r_ram[w_ram_idx];
      end else if (w_sel_mmio) begin
        case (w_reg)
          c_reg_status: data_o = {{(WORD_BITWIDTH-3){1'b0}}, r_overflow, w_full, w_empty};
          c_reg_lo:     data_o = r_cycle[WORD_BITWIDTH-1:0];
          c_reg_hi:     data_o = r_hi_snap;
          default:      data_o = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
      r_hi_snap  <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_cycle <= r_cycle + c_cycle_one;
      // Snapshot the upper word at the LO read so a later HI read is coherent.
      if (w_lo_rd) begin
        r_hi_snap <= r_cycle[2*WORD_BITWIDTH-1:WORD_BITWIDTH];
      end
      if ((data_ce_i || data_we_i) && w_unmapped) begin
        r_bad <= 1'b1;
      end
      if (w_status_wr) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_we_i && w_sel_ram) begin
      r_ram[w_ram_idx] <= data_i;
    end
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= data_i[7:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_mmio                                                    |
// | Brief    : Scoreboard bench for dmem_mmio against a queue/array model.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        bad_access_o;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk          (clk),
    .rst          (rst),
    .data_ce_i    (data_ce_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i),
    .bad_access_o (bad_access_o)
  );

  typedef struct {
    logic [31:0] rd;
    logic        valid;
    logic [7:0]  head;
    logic        bad;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sb_tx[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: plain arrays and queues.
  logic [31:0] m_ram[int];
  logic [7:0]  m_fifo[$];
  logic        m_ovf;
  logic [63:0] m_cyc;
  logic [31:0] m_snap;
  logic        m_bad;
  int          widx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:28] == 4'h0;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off;
    if (is_ram(a)) return m_ram.exists(ram_idx(a)) ? m_ram[ram_idx(a)] : 32'h0;
    if (!is_mmio(a)) return 32'h0;
    off = int'(a - BASE) / 4;
    case (off)
      1: return {29'b0, m_ovf, m_fifo.size() == 8, m_fifo.size() == 0};
      2: return m_cyc[31:0];
      3: return m_snap;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, record the expected outputs, then advance the model at the edge.
  task automatic step(input bit ce, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    exp_t e;
    bit   pop, full;
    int   off;
    data_ce_i = ce; data_we_i = we; data_addr_i = a; data_i = d; tx_ready_i = rdy;
    e.rd    = ce ? m_read(a) : 32'h0;
    e.valid = m_fifo.size() != 0;
    e.head  = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
    e.bad   = m_bad;
    sb.push_back(e);
    @(posedge clk);
    pop  = (m_fifo.size() != 0) && rdy;
    full = m_fifo.size() == 8;
    off  = int'(a - BASE) / 4;
    if (pop) void'(m_fifo.pop_front());
    if (we && is_mmio(a) && off == 0) begin
      if (!full || pop) begin
        m_fifo.push_back(d[7:0]);
        sb_tx.push_back(d[7:0]);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (we && is_mmio(a) && off == 1) m_ovf = 1'b0;
    if (we && is_ram(a)) begin
      m_ram[ram_idx(a)] = d;
      widx.push_back(ram_idx(a));
    end
    if (ce && is_mmio(a) && off == 2) m_snap = m_cyc[63:32];
    if ((ce || we) && !is_ram(a) && !is_mmio(a)) m_bad = 1'b1;
    m_cyc = m_cyc + 64'd1;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    data_ce_i = 1'b0; data_we_i = 1'b0; tx_ready_i = 1'b0;
    rst = 1'b1;
    sb.delete(); sb_tx.delete(); m_fifo.delete();
    m_ovf = 1'b0; m_cyc = 64'd0; m_snap = 32'd0; m_bad = 1'b0;
    #1;
    check("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data_o}, 32'd0);
    check("rst_bad", {31'b0, bad_access_o}, 32'd0);
    data_ce_i = 1'b1; data_addr_i = BASE + 32'h4;
    #1 check("rst_status", data_o, 32'h1);
    data_addr_i = BASE + 32'h8;
    #1 check("rst_cycle_lo", data_o, 32'h0);
    data_addr_i = BASE + 32'hC;
    #1 check("rst_cycle_hi", data_o, 32'h0);
    data_ce_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data_o", data_o, e.rd);
      check("tx_valid", {31'b0, tx_valid_o}, {31'b0, e.valid});
      check("tx_head", {24'b0, tx_data_o}, {24'b0, e.head});
      check("bad_access", {31'b0, bad_access_o}, {31'b0, e.bad});
    end
    if (!rst && tx_valid_o && tx_ready_i) begin
      if (sb_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_pop actual=%h expected=none", tx_data_o);
      end else begin
        check("tx_pop", {24'b0, tx_data_o}, {24'b0, sb_tx.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          op;
    data_addr_i = 32'h0; data_i = 32'h0;
    do_reset();

    // RAM write/read, ignored low bits, read-during-write
    step(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    step(0, 1, 32'h44, 32'hDEAD_BEEF, 0);

    // Console ordering with a held head
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, BASE, 32'h41 + i, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);

    // Overflow, clear, full push+pop
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, BASE, 32'h10 + i, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
    step(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
    step(1'b0, 1'b1, BASE, 32'h99, 1'b1);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
    idle(9, 1'b1);

    // Randomized mix of mapped accesses
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 8));
      case (op)
        0: step(1'b0, 1'b1, ($urandom & 32'h0FFF_FFFF), $urandom, $urandom_range(0, 1) == 1);
        1: begin
          a = (widx.size() == 0) ? 32'h40
              : (($urandom & 32'h0FFF_F000) | (widx[$urandom_range(0, widx.size() - 1)] << 2)
                 | ($urandom & 32'h3));
          step(1'b1, $urandom_range(0, 3) == 0, a, $urandom, $urandom_range(0, 1) == 1);
        end
        2, 3: step(1'b0, 1'b1, BASE, $urandom, $urandom_range(0, 2) == 0);
        4: step(1'b1, 1'b0, BASE + 32'h4, 32'h0, $urandom_range(0, 1) == 1);
        5: step(1'b0, 1'b1, BASE + 32'h4, $urandom, $urandom_range(0, 1) == 1);
        6: step(1'b1, 1'b0, BASE + 32'h8, 32'h0, $urandom_range(0, 1) == 1);
        7: step(1'b1, 1'b0, BASE + 32'hC, 32'h0, $urandom_range(0, 1) == 1);
        default: step(1'b1, 1'b0, BASE, 32'h0, $urandom_range(0, 1) == 1);
      endcase
    end
    idle(10, 1'b1);

    // Cycle counter from reset, then coherent LO/HI across a carry
    do_reset();
    idle(100, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
    dut.r_cycle = 64'h0000_0007_FFFF_FFFE;
    m_cyc       = 64'h0000_0007_FFFF_FFFE;
    idle(1, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, BASE + 32'hC, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);

    // Unmapped access sets a sticky flag
    step(1'b1, 1'b0, 32'h2000_0000, 32'h0, 1'b0);
    idle(10, 1'b0);
    step(1'b0, 1'b1, 32'h3000_0010, 32'h5555_5555, 1'b0);

    // Reset with bytes pending flushes the FIFO; RAM survives
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, BASE, 32'hA0 + i, 1'b0);
    do_reset();
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    idle(3, 1'b1);
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
